// File: rtl/alu_pkg.sv
// Shared types and opcode constants for the ALU and its two-port arbiter.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  typedef logic [3:0] alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; undefined opcodes pass in0 through, ADD/SUB wrap modulo 2^N.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  alu_op_t        op,
  input  logic [N-1:0]   in0,
  input  logic [N-1:0]   in1,
  output logic [N-1:0]   result
);

  // Opcode decode
  always_comb begin
    result = in0;
    case (op)
      OP_ADD:  result = in0 + in1;
      OP_SUB:  result = in0 - in1;
      OP_AND:  result = in0 & in1;
      OP_OR:   result = in0 | in1;
      OP_XOR:  result = in0 ^ in1;
      default: result = in0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one transaction in flight.
// Optional flag outputs (rsp_zero, rsp_carry) are enabled by defining ALU_ARBITER_FLAGS_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [7:0]     req_op,
  input  logic [2*N-1:0] req_in0,
  input  logic [2*N-1:0] req_in1,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [N-1:0]   rsp_data,
  output logic           busy
`ifdef ALU_ARBITER_FLAGS_EN
  ,
  output logic           rsp_zero,
  output logic           rsp_carry
`endif
);

  arb_state_t   state_q, state_d;
  logic         last_grant_q;
  logic         owner_q;
  alu_op_t      op_q;
  logic [N-1:0] in0_q, in1_q;
  logic [N-1:0] rsp_data_q;
  logic [N-1:0] alu_result;
  logic         grant;
  logic         handshake;

  // Grant: sole requester wins; on contention the one not served last wins
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase
  end

  // Ready only in IDLE, one-hot of grant, zero when nobody is asking
  always_comb begin
    req_ready = 2'b00;
    if (state_q == IDLE && req_valid != 2'b00) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end
  end

  assign handshake = |(req_valid & req_ready);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, arbitration history and operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= OP_ADD;
      in0_q        <= '0;
      in1_q        <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        last_grant_q <= grant;
        owner_q      <= grant;
        op_q         <= grant ? req_op[7:4] : req_op[3:0];
        in0_q        <= grant ? req_in0[2*N-1:N] : req_in0[N-1:0];
        in1_q        <= grant ? req_in1[2*N-1:N] : req_in1[N-1:0];
      end
    end
  end

  alu #(
    .N (N)
  ) u_alu (
    .op     (op_q),
    .in0    (in0_q),
    .in1    (in1_q),
    .result (alu_result)
  );

  // Result register: written only in EXEC, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
    end else if (state_q == EXEC) begin
      rsp_data_q <= alu_result;
    end
  end

`ifdef ALU_ARBITER_FLAGS_EN
  logic         zero_q, carry_q;
  logic         carry_d;
  logic [N:0]   sum_ext;

  // Carry-out for ADD, unsigned borrow for SUB, zero otherwise
  always_comb begin
    sum_ext = {1'b0, in0_q} + {1'b0, in1_q};
    carry_d = 1'b0;
    case (op_q)
      OP_ADD:  carry_d = sum_ext[N];
      OP_SUB:  carry_d = (in0_q < in1_q);
      default: carry_d = 1'b0;
    endcase
  end

  // Flags registered alongside rsp_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (state_q == EXEC) begin
      zero_q  <= (alu_result == '0);
      carry_q <= carry_d;
    end
  end

  assign rsp_zero  = zero_q;
  assign rsp_carry = carry_q;
`endif

  assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [15:0] req_in0;
  logic [15:0] req_in1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_data;
  logic        busy;
`ifdef ALU_ARBITER_FLAGS_EN
  logic        rsp_zero;
  logic        rsp_carry;
`endif

  int tests = 0;
  int fails = 0;
  bit last_served;  // model: requester served most recently

  alu_arbiter #(
    .N (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_in0   (req_in0),
    .req_in1   (req_in1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef ALU_ARBITER_FLAGS_EN
    ,
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference ALU from the opcode table
  function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int s;
    case (op)
      4'd0:    begin s = int'(a) + int'(b);       ref_alu = 8'(s % 256); end
      4'd1:    begin s = int'(a) - int'(b) + 256; ref_alu = 8'(s % 256); end
      4'd2:    ref_alu = a & b;
      4'd3:    ref_alu = a | b;
      4'd4:    ref_alu = a ^ b;
      default: ref_alu = a;
    endcase
  endfunction

  function automatic logic ref_carry(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] b);
    if (op == 4'd0) ref_carry = (int'(a) + int'(b)) > 255;
    else if (op == 4'd1) ref_carry = int'(a) < int'(b);
    else ref_carry = 1'b0;
  endfunction

  // Model winner: the only requester, or the one not served last
  function automatic bit ref_winner(input logic [1:0] v);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return ~last_served;
  endfunction

  // One full transaction; stall = RESP cycles with only the wrong rsp_ready bit asserted
  task automatic transact(input logic [1:0] v, input logic [3:0] op0, input logic [7:0] a0,
                          input logic [7:0] b0, input logic [3:0] op1, input logic [7:0] a1,
                          input logic [7:0] b1, input int stall);
    bit          g;
    logic [3:0]  op;
    logic [7:0]  a, b, exp;
    g   = ref_winner(v);
    op  = g ? op1 : op0;
    a   = g ? a1 : a0;
    b   = g ? b1 : b0;
    exp = ref_alu(op, a, b);
    req_valid = v;
    req_op    = {op1, op0};
    req_in0   = {a1, a0};
    req_in1   = {b1, b0};
    #1;
    check("idle_ready", 32'(req_ready), g ? 32'h2 : 32'h1);
    check("idle_busy", 32'(busy), 32'h0);
    tick;  // handshake edge
    req_valid = 2'b00;
    req_op    = 8'hxx;
    req_in0   = 16'hxxxx;
    req_in1   = 16'hxxxx;
    #1;
    check("exec_ready", 32'(req_ready), 32'h0);
    check("exec_valid", 32'(rsp_valid), 32'h0);
    check("exec_busy", 32'(busy), 32'h1);
    tick;
    check("resp_valid", 32'(rsp_valid), g ? 32'h2 : 32'h1);
    check("resp_data", 32'(rsp_data), 32'(exp));
`ifdef ALU_ARBITER_FLAGS_EN
    check("resp_zero", 32'(rsp_zero), 32'(exp == 8'h00));
    check("resp_carry", 32'(rsp_carry), 32'(ref_carry(op, a, b)));
`endif
    for (int i = 0; i < stall; i++) begin
      rsp_ready = g ? 2'b01 : 2'b10;
      req_valid = 2'b11;
      #1;
      check("stall_ready", 32'(req_ready), 32'h0);
      tick;
      check("stall_valid", 32'(rsp_valid), g ? 32'h2 : 32'h1);
      check("stall_data", 32'(rsp_data), 32'(exp));
      check("stall_busy", 32'(busy), 32'h1);
    end
    req_valid = 2'b00;
    rsp_ready = g ? 2'b10 : 2'b01;
    tick;
    rsp_ready = 2'b00;
    #1;
    check("done_busy", 32'(busy), 32'h0);
    check("done_valid", 32'(rsp_valid), 32'h0);
    check("done_hold", 32'(rsp_data), 32'(exp));
    last_served = g;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 2'b00;
    req_op      = 8'h00;
    req_in0     = 16'h0000;
    req_in1     = 16'h0000;
    rsp_ready   = 2'b00;
    last_served = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_data", 32'(rsp_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    check("idle_noreq_ready", 32'(req_ready), 32'h0);

    // Single request: ADD 0x7F + 0x02 = 0x81
    transact(2'b01, 4'd0, 8'h7F, 8'h02, 4'd0, 8'h00, 8'h00, 0);
    check("add_model", 32'(ref_alu(4'd0, 8'h7F, 8'h02)), 32'h81);

    // Contention: req0 SUB 05-07 = FE, req1 XOR F0^FF = 0F, alternating
    for (int i = 0; i < 3; i++) begin
      transact(2'b11, 4'd1, 8'h05, 8'h07, 4'd4, 8'hF0, 8'hFF, 0);
    end

    // Backpressure with wrong-bit rsp_ready for 10 cycles
    transact(2'b10, 4'd0, 8'h00, 8'h00, 4'd3, 8'h12, 8'h40, 10);

    // Undefined opcode passes in0; AND and OR
    transact(2'b01, 4'd9, 8'h3C, 8'hAA, 4'd0, 8'h00, 8'h00, 0);
    transact(2'b10, 4'd0, 8'h00, 8'h00, 4'd2, 8'h3C, 8'hAA, 0);
    transact(2'b01, 4'd3, 8'h3C, 8'hAA, 4'd0, 8'h00, 8'h00, 0);

    // Reset during EXEC drops the transaction
    req_valid = 2'b01;
    req_op    = 8'h00;
    req_in0   = 16'h0011;
    req_in1   = 16'h0022;
    tick;
    req_valid = 2'b00;
    #1;
    check("pre_rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_data", 32'(rsp_data), 32'h0);
    tick;
    check("mid_rst_valid2", 32'(rsp_valid), 32'h0);
    rst_n       = 1'b1;
    last_served = 1'b1;
    tick;
    check("post_rst_valid", 32'(rsp_valid), 32'h0);
    transact(2'b11, 4'd4, 8'h0F, 8'h01, 4'd0, 8'h01, 8'h01, 0);

`ifdef ALU_ARBITER_FLAGS_EN
    transact(2'b01, 4'd0, 8'hFF, 8'h01, 4'd0, 8'h00, 8'h00, 0);
    transact(2'b10, 4'd0, 8'h00, 8'h00, 4'd1, 8'h02, 8'h03, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(1, 3));
      transact(v, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
               4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
               int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
